// File: rtl/apb_pkg.sv
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the APB completer: transfer
//                phase encoding, PWRITE direction values and wait-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  // Bus phase as seen by the completer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ  = 1'b0;

  // Width of the wait-state counter (WAIT_STATES range 0..15)
  localparam int WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/apb_fifo.sv
// ============================================================================
//  Module      : apb_fifo
//  Description : Synchronous FIFO with occupancy count. Push is ignored when
//                full, pop is ignored when empty. Head reads 0 while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_fifo
  import apb_pkg::*;
#(
  parameter int m     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [m-1:0]             push_data,
  input  logic                     pop,
  output logic [m-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [m-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; no reset needed since head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/apb_completer.sv
// ============================================================================
//  Module      : apb_completer
//  Description : APB completer. Writes push PWDATA into a FIFO drained over a
//                valid/ready port; reads return 1 on PRDATA when the FIFO is
//                empty. Wait states come from a fixed per-transfer count and
//                from FIFO back-pressure on writes.
//                Optional macro APB_COMPLETER_SLVERR_EN: adds PSLVERR and turns
//                a write to a full FIFO into an error completion (data dropped)
//                instead of a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_completer
  import apb_pkg::*;
#(
  parameter int m           = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [m-1:0]            PWDATA,
  output logic                    PREADY,
  output logic                    PRDATA,
`ifdef APB_COMPLETER_SLVERR_EN
  output logic                    PSLVERR,
`endif
  output logic [m-1:0]            o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count
);

  apb_state_e             state;
  apb_state_e             state_nxt;
  apb_state_e             phase;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   wr_q;
  logic [m-1:0]           wdata_q;
  logic                   full;
  logic                   empty;
  logic                   complete;
  logic                   push;

  // The register remembers whether a transfer is in its ACCESS phase; a
  // SETUP phase is recognised from the live bus so that the ACCESS phase of
  // the bus and of the completer line up in the same cycle.
  always_comb begin
    phase = state;
    if (state == IDLE && PSEL && !PENABLE) phase = SETUP;
  end

  // Next state: SETUP always moves to ACCESS; ACCESS ends on completion or
  // when PSEL drops (abort). A back-to-back transfer re-enters SETUP via the
  // live decode above in the cycle after completion.
  always_comb begin
    state_nxt = state;
    case (phase)
      IDLE:    state_nxt = IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (!PSEL || complete) ? IDLE : ACCESS;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Wait counter loads on entry to ACCESS and counts down to zero
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wait_cnt <= '0;
    end else if (phase == SETUP) begin
      wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
    end else if (phase == ACCESS && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Direction and data are captured at the end of SETUP; later changes ignored
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wr_q    <= APB_READ;
      wdata_q <= '0;
    end else if (phase == SETUP) begin
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

`ifdef APB_COMPLETER_SLVERR_EN
  // Full FIFO never stalls; the write completes with an error instead
  always_comb begin
    PREADY  = 1'b1;
    if (phase == ACCESS) PREADY = (wait_cnt == '0);
    PSLVERR = complete && (wr_q == APB_WRITE) && full;
  end
`else
  // Full is judged on the pre-pop count, so a same-cycle pop still stalls
  always_comb begin
    PREADY = 1'b1;
    if (phase == ACCESS) PREADY = (wait_cnt == '0) && !((wr_q == APB_WRITE) && full);
  end
`endif

  assign complete = (phase == ACCESS) && PSEL && PENABLE && PREADY;
  assign push     = complete && (wr_q == APB_WRITE) && !full;
  assign PRDATA   = (phase == ACCESS) && (wr_q == APB_READ) && (o_count == '0);
  assign o_valid  = ~empty;

  apb_fifo #(
    .m     (m),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (PCLK),
    .rst_n     (PRESET),
    .push      (push),
    .push_data (wdata_q),
    .pop       (i_ready),
    .head      (o_data),
    .full      (full),
    .empty     (empty),
    .count     (o_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_apb_completer.sv
// ============================================================================
//  Module      : tb_apb_completer
//  Description : Directed bench for apb_completer. Three instances share the
//                bus and differ in WAIT_STATES (0, 3, 2); each has its own
//                PSEL and i_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_completer;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [2:0]      psel;
  logic            penable;
  logic            pwrite;
  logic [7:0]      pwdata;
  logic [2:0]      pready;
  logic [2:0]      prdata;
  logic [2:0]      ovalid;
  logic [2:0]      iready;
  logic [2:0][7:0] odata;
  logic [2:0][2:0] cnt;
`ifdef APB_COMPLETER_SLVERR_EN
  logic [2:0]      pslverr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_completer #(.m(8), .DEPTH(4), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
`ifdef APB_COMPLETER_SLVERR_EN
    .PSLVERR(pslverr[0]),
`endif
    .o_data(odata[0]), .o_valid(ovalid[0]), .i_ready(iready[0]), .o_count(cnt[0])
  );

  apb_completer #(.m(8), .DEPTH(4), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
`ifdef APB_COMPLETER_SLVERR_EN
    .PSLVERR(pslverr[1]),
`endif
    .o_data(odata[1]), .o_valid(ovalid[1]), .i_ready(iready[1]), .o_count(cnt[1])
  );

  apb_completer #(.m(8), .DEPTH(4), .WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
`ifdef APB_COMPLETER_SLVERR_EN
    .PSLVERR(pslverr[2]),
`endif
    .o_data(odata[2]), .o_valid(ovalid[2]), .i_ready(iready[2]), .o_count(cnt[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One APB transfer on instance k, entered and left at posedge+1.
  // cnt_before is the occupancy expected throughout the ACCESS phase.
  task automatic xfer(input int k, input logic wr, input logic [7:0] d, input bit keep,
                      input logic [2:0] cnt_before, output int acc, output logic rd_flag);
    bit done;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d;
    @(posedge PCLK); #1;
    penable = 1'b1;
    acc = 0; done = 0; rd_flag = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      acc++;
      check("cnt_in_access", {29'd0, cnt[k]}, {29'd0, cnt_before});
      if (pready[k]) begin
        done = 1;
        rd_flag = prdata[k];
      end else if (acc > 40) begin
        check("xfer_timeout", acc, 0);
        done = 1;
      end
      @(posedge PCLK); #1;
    end
    penable = 1'b0;
    if (!keep) psel[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic rf;
    PRESET = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; iready = '0;

    // Reset values, no traffic
    #2;
    check("rst_pready", pready, 3'b111);
    check("rst_prdata", prdata, 3'b000);
    check("rst_valid",  ovalid, 3'b000);
    check("rst_count",  cnt[0], 0);
    check("rst_odata",  odata[0], 0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;

    // WAIT_STATES=0: write 0xA5, then read flags around a single pop
    xfer(0, 1'b1, 8'hA5, 0, 3'd0, acc, rf);
    check("w0_latency", acc, 1);
    check("w0_count", cnt[0], 1);
    check("w0_odata", odata[0], 8'hA5);
    check("w0_valid", ovalid[0], 1);
    xfer(0, 1'b0, 8'h00, 0, 3'd1, acc, rf);
    check("rd_not_empty", rf, 0);
    iready[0] = 1'b1;
    @(posedge PCLK); #1;
    iready[0] = 1'b0;
    check("pop_count", cnt[0], 0);
    check("pop_valid", ovalid[0], 0);
    xfer(0, 1'b0, 8'h00, 0, 3'd0, acc, rf);
    check("rd_empty", rf, 1);

    // WAIT_STATES=3: three stalled ACCESS cycles, push on the fourth edge
    xfer(1, 1'b1, 8'h3C, 0, 3'd0, acc, rf);
    check("ws3_latency", acc, 4);
    check("ws3_count", cnt[1], 1);
    check("ws3_odata", odata[1], 8'h3C);

    // DEPTH=4: fill the FIFO back-to-back
    for (int i = 1; i <= 4; i++) begin
      xfer(0, 1'b1, 8'(i), 1, 3'(i - 1), acc, rf);
      check("fill_latency", acc, 1);
      check("fill_count", cnt[0], i);
    end
`ifdef APB_COMPLETER_SLVERR_EN
    // Write to full FIFO: error completion, data dropped
    penable = 1'b0; pwrite = 1'b1; pwdata = 8'h77;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("err_pready", pready[0], 1);
    check("err_pslverr", pslverr[0], 1);
    check("err_count_in", cnt[0], 4);
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable = 1'b0;
    check("err_pslverr_after", pslverr[0], 0);
    check("err_count", cnt[0], 4);
    iready[0] = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge PCLK);
      check("drain_err", odata[0], j);
      @(posedge PCLK); #1;
    end
    iready[0] = 1'b0;
    check("drain_err_valid", ovalid[0], 0);
`else
    // Fifth write stalls until a pop frees an entry
    penable = 1'b0; pwrite = 1'b1; pwdata = 8'h05;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("stall_pready_1", pready[0], 0);
    check("stall_count", cnt[0], 4);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("stall_pready_2", pready[0], 0);
    @(posedge PCLK); #1;
    iready[0] = 1'b1;
    @(negedge PCLK);
    check("stall_pready_pop", pready[0], 0);
    @(posedge PCLK); #1;
    iready[0] = 1'b0;
    @(negedge PCLK);
    check("stall_release", pready[0], 1);
    check("stall_count_pop", cnt[0], 3);
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable = 1'b0;
    check("fifth_count", cnt[0], 4);
    iready[0] = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      @(negedge PCLK);
      check("drain_order", odata[0], j);
      @(posedge PCLK); #1;
    end
    iready[0] = 1'b0;
    check("drain_valid", ovalid[0], 0);
`endif

    // WAIT_STATES=2: abort by dropping PSEL, then a normal transfer
    xfer(2, 1'b1, 8'h11, 0, 3'd0, acc, rf);
    check("ws2_latency", acc, 3);
    check("ws2_count", cnt[2], 1);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h22;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("abort_pready", pready[2], 0);
    @(posedge PCLK); #1;
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("abort_count", cnt[2], 1);
    check("abort_idle_ready", pready[2], 1);
    @(posedge PCLK); #1;
    xfer(2, 1'b1, 8'h33, 0, 3'd1, acc, rf);
    check("post_abort_latency", acc, 3);
    check("post_abort_count", cnt[2], 2);
    check("post_abort_head", odata[2], 8'h11);

    // Asynchronous reset in the middle of an ACCESS phase
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h99;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("mid_pready", pready[1], 0);
    #2;
    PRESET = 1'b0;
    #1;
    check("arst_pready", pready[1], 1);
    check("arst_prdata", prdata[1], 0);
    check("arst_count", cnt[1], 0);
    check("arst_valid", ovalid[1], 0);
    check("arst_odata", odata[1], 0);
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("arst_count_after", cnt[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_completer.md
Name: apb_completer

Overview:
- APB completer (slave) for the peripheral end of the APB bus: accepts write transfers of PWDATA into an internal FIFO and answers read transfers with a 1-bit "all data drained" flag on PRDATA.
- Inserts wait states through PREADY, either a fixed per-transfer count or FIFO back-pressure.
- One instance sits behind each PSELx line. The downstream consumer drains the FIFO over a valid/ready interface.

Parameters:
- m, 8, data width of PWDATA and o_data.
- DEPTH, 4, FIFO depth in entries; must be a power of 2, minimum 2.
- WAIT_STATES, 0, extra ACCESS cycles inserted before PREADY may rise; range 0..15.

Ports:
- PCLK  input  1  clock; all state updates on the rising edge.
- PRESET  input  1  reset, asynchronous, active-low.
- PSEL  input  1  select for this completer.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  m  write data.
- PREADY  output  1  transfer-completion / wait-state control.
- PRDATA  output  1  read response: 1 = FIFO empty (all written data consumed).
- o_data  output  m  FIFO head entry.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts o_data when o_valid & i_ready.
- o_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (PRESET=0, asynchronous): FSM goes to IDLE, FIFO is emptied, wait counter clears to 0. Output values while in reset:
  - PREADY=1
  - PRDATA=0
  - o_valid=0
  - o_count=0
  - o_data=0
- Reset mid-transfer aborts the transfer. Any data not yet pushed is discarded.
- FSM states:
  - IDLE: default state.
  - SETUP: entered from IDLE, or from ACCESS after a completion, when PSEL & ~PENABLE is sampled.
  - ACCESS: entered from SETUP unconditionally on the next edge. On that transition the wait counter loads WAIT_STATES and PWRITE/PWDATA are captured.
  - ACCESS -> IDLE: on completion when PSEL is low next, or at once if PSEL drops before completion (abort, no push).
  - ACCESS -> SETUP: back-to-back transfer.
- Wait counter: decrements by 1 each ACCESS cycle while non-zero and saturates at 0.
- PREADY (combinational):
  - In ACCESS: PREADY = (wait_cnt==0) & ~(write & full).
  - In all other states: PREADY = 1, so an idle initiator sees the bus ready.
- Completion = ACCESS & PSEL & PENABLE & PREADY at a rising edge.
  - Write completion pushes the captured PWDATA.
  - Read completion pushes nothing.
- Latency: with WAIT_STATES=0 and the FIFO not full, a transfer takes 2 cycles (SETUP + 1 ACCESS). Each wait state adds 1 cycle.
- PRDATA:
  - During a read ACCESS: PRDATA = (o_count==0).
  - Otherwise PRDATA = 0.
- FIFO:
  - Pop on o_valid & i_ready; no pop when empty.
  - Push and pop in the same cycle leave o_count unchanged.
  - Full is evaluated on the pre-pop count. A write to a full FIFO stalls even if a pop occurs the same cycle, and completes on the following cycle.
  - Pointers wrap modulo DEPTH.
- Protocol violations are ignored:
  - PENABLE without a prior SETUP keeps the FSM in IDLE.
  - PWRITE/PWDATA changes during ACCESS are ignored because the SETUP values were captured.

Optional Feature:
- Macro: APB_COMPLETER_SLVERR_EN.
- Defined:
  - Adds output PSLVERR (1 bit, reset 0).
  - A write to a full FIFO does not stall. PREADY follows wait_cnt only, the transfer completes with PSLVERR=1 during the completing cycle, and the data is dropped.
  - PSLVERR=0 in all other cycles.
- Undefined: no PSLVERR port; writes to a full FIFO stall as described above.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS)
  - APB_WRITE=1'b1 and APB_READ=1'b0
  - the wait-counter width constant (4)
- Sub-module apb_fifo: synchronous FIFO (m, DEPTH) with push, pop, full, empty and count outputs.

Test Plan:
- Reset with no traffic: PREADY=1, PRDATA=0, o_valid=0, o_count=0. Then assert PRESET low mid-ACCESS: outputs return to reset values asynchronously.
- WAIT_STATES=0, write 0xA5 with i_ready=0 -> PREADY=1 in the first ACCESS cycle, o_count=1, o_data=0xA5. A following read -> PRDATA=0; raise i_ready for one cycle, read again -> PRDATA=1.
- WAIT_STATES=3, single write -> PREADY low for 3 ACCESS cycles, high on the 4th; the push occurs on the 4th-cycle edge only.
- DEPTH=4, i_ready=0, 5 back-to-back writes 0x01..0x05:
  - First four complete; the fifth stalls with PREADY=0.
  - Pulse i_ready for one cycle -> the fifth completes on the next cycle, o_count=4, FIFO drains 0x02..0x05 in order.
- PSEL dropped during a WAIT_STATES=2 ACCESS -> FSM returns to IDLE, o_count unchanged, the next transfer completes normally.
- With APB_COMPLETER_SLVERR_EN: FIFO full, write 0x77 -> completes in 2 cycles with PSLVERR=1, o_count stays 4, 0x77 never appears on o_data.
